// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-stage holding register with bypass operand resolution
// and load-use interlock.
module id_operand_stage #(
  parameter int XLEN = 32,
  parameter int NUM_BYP = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  input  logic                    flush,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_BYP-1:0]      byp_valid,
  input  logic [NUM_BYP-1:0]      byp_pending,
  input  logic [5*NUM_BYP-1:0]    byp_waddr,
  input  logic [XLEN*NUM_BYP-1:0] byp_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_inst,
  output logic [XLEN-1:0]         out_rs_val,
  output logic [XLEN-1:0]         out_rt_val,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        stall_cycles
);
  typedef enum logic [1:0] {EMPTY, VALID, STALL} state_t;
  state_t state, state_nx;
  logic [5:0] op, func;
  logic [4:0] rs, rt;
  logic uses_rs, uses_rt, rs_pend, rt_pend, hazard, capture, xfer;
  assign op = out_inst[31:26];
  assign func = out_inst[5:0];
  assign rs = out_inst[25:21];
  assign rt = out_inst[20:16];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;
  assign uses_rs = !(op == 6'b001111 || op == 6'b000010 || op == 6'b000011 ||
                     (op == 6'b000000 && (func == 6'b000000 || func == 6'b000010 || func == 6'b000011)));
  assign uses_rt = op == 6'b000000 || op == 6'b000100 || op == 6'b000101 || op[5:3] == 3'b101;
  // Walk oldest to youngest so the lowest-index match overrides.
  always_comb begin
    out_rs_val = rf_rdata1;
    out_rt_val = rf_rdata2;
    rs_pend = 1'b0;
    rt_pend = 1'b0;
    for (int i = NUM_BYP - 1; i >= 0; i--) begin
      if (byp_valid[i] && byp_waddr[5*i +: 5] == rs && rs != 5'd0) begin
        out_rs_val = byp_wdata[XLEN*i +: XLEN];
        rs_pend = byp_pending[i];
      end
      if (byp_valid[i] && byp_waddr[5*i +: 5] == rt && rt != 5'd0) begin
        out_rt_val = byp_wdata[XLEN*i +: XLEN];
        rt_pend = byp_pending[i];
      end
    end
  end
  assign hazard = (uses_rs && rs_pend) || (uses_rt && rt_pend);
  assign out_valid = state != EMPTY && !hazard;
  assign xfer = out_valid && out_ready;
  assign in_ready = state == EMPTY || xfer;
  assign capture = in_valid && in_ready && !flush;
  always_comb
    state_nx = flush ? EMPTY :
               capture ? VALID :
               (state == EMPTY || xfer) ? EMPTY :
               hazard ? STALL : VALID;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      out_pc <= '0;
      out_inst <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        out_pc <= in_pc;
        out_inst <= in_inst;
      end
      if (clr_cnt) stall_cycles <= '0;
      else if (state != EMPTY && hazard && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed vector table, multi-cycle corner sequences and a
// randomized run against a behavioural model of the decode stage.
module tb_id_operand_stage;
  localparam int XLEN = 32;
  localparam int NB = 2;
  localparam int CW = 4;
  logic clk, rst, in_valid, in_ready, flush, out_valid, out_ready, clr_cnt;
  logic [XLEN-1:0] in_pc, rf_rdata1, rf_rdata2, out_pc, out_rs_val, out_rt_val;
  logic [31:0] in_inst, out_inst;
  logic [4:0] rf_raddr1, rf_raddr2;
  logic [NB-1:0] byp_valid, byp_pending;
  logic [5*NB-1:0] byp_waddr;
  logic [XLEN*NB-1:0] byp_wdata;
  logic [CW-1:0] stall_cycles;
  logic [4:0] wa [NB];
  logic [31:0] wd [NB];
  int checks = 0, errors = 0;

  assign byp_waddr = {wa[1], wa[0]};
  assign byp_wdata = {wd[1], wd[0]};

  id_operand_stage #(.XLEN(XLEN), .NUM_BYP(NB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .byp_valid(byp_valid),
    .byp_pending(byp_pending), .byp_waddr(byp_waddr), .byp_wdata(byp_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .clr_cnt(clr_cnt),
    .stall_cycles(stall_cycles));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [1:0] bv, bp;
    logic [4:0] wa0, wa1;
    logic [31:0] wd0, wd1, rf1, rf2, ers, ert;
    logic ev;
  } vec_t;
  vec_t v [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic byp(input logic [1:0] bv, input logic [1:0] bp, input logic [4:0] a0,
                     input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    byp_valid = bv;
    byp_pending = bp;
    wa[0] = a0;
    wa[1] = a1;
    wd[0] = d0;
    wd[1] = d1;
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc = pc;
    in_inst = inst;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    byp(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    step();
    out_ready = 1'b0;
    clr_cnt = 1'b0;
  endtask

  // Reference model: decode and resolution straight from the instruction-set rules.
  function automatic logic m_uses_rs(input logic [31:0] ins);
    logic [5:0] o, f;
    o = ins[31:26];
    f = ins[5:0];
    if (o == 6'h0f || o == 6'h02 || o == 6'h03) return 1'b0;
    if (o == 6'h00 && (f == 6'h00 || f == 6'h02 || f == 6'h03)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_uses_rt(input logic [31:0] ins);
    logic [5:0] o;
    o = ins[31:26];
    return o == 6'h00 || o == 6'h04 || o == 6'h05 || o == 6'h28 || o == 6'h29 ||
           o == 6'h2a || o == 6'h2b || o == 6'h2c || o == 6'h2d || o == 6'h2e || o == 6'h2f;
  endfunction

  task automatic m_res(input logic [4:0] r, input logic [31:0] rf, output logic [31:0] val,
                       output logic pend);
    val = rf;
    pend = 1'b0;
    if (r == 5'd0) return;
    for (int i = 0; i < NB; i++)
      if (byp_valid[i] && wa[i] == r) begin
        val = wd[i];
        pend = byp_pending[i];
        return;
      end
  endtask

  logic m_held;
  logic [31:0] m_pc, m_inst;
  int m_cnt;

  initial begin
    logic [31:0] rsv, rtv;
    logic prs, prt, haz, ev, er;
    logic [5:0] ops [9];
    logic [5:0] fns [4];
    ops = '{6'h00, 6'h0f, 6'h02, 6'h03, 6'h04, 6'h05, 6'h2b, 6'h23, 6'h08};
    fns = '{6'h00, 6'h02, 6'h03, 6'h21};
    v[0]  = '{32'h00221821, 2'b01, 2'b00, 5'd1, 5'd0, 32'hAAAA0001, 32'h0, 32'd5, 32'd7, 32'hAAAA0001, 32'd7, 1'b1};
    v[1]  = '{32'h00221821, 2'b11, 2'b00, 5'd2, 5'd2, 32'h11, 32'h22, 32'd5, 32'd7, 32'd5, 32'h11, 1'b1};
    v[2]  = '{32'h00221821, 2'b11, 2'b10, 5'd2, 5'd2, 32'h11, 32'h22, 32'd5, 32'd7, 32'd5, 32'h11, 1'b1};
    v[3]  = '{32'h00221821, 2'b01, 2'b01, 5'd1, 5'd0, 32'hAAAA0001, 32'h0, 32'd5, 32'd7, 32'hAAAA0001, 32'd7, 1'b0};
    v[4]  = '{32'h00221821, 2'b01, 2'b01, 5'd0, 5'd0, 32'h99, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 1'b1};
    v[5]  = '{32'h3C010005, 2'b01, 2'b01, 5'd1, 5'd0, 32'h33, 32'h0, 32'd5, 32'd7, 32'd5, 32'h33, 1'b1};
    v[6]  = '{32'h00221821, 2'b10, 2'b10, 5'd0, 5'd2, 32'h0, 32'h22, 32'd5, 32'd7, 32'd5, 32'h22, 1'b0};
    v[7]  = '{32'h0BE00000, 2'b01, 2'b01, 5'd31, 5'd0, 32'h44, 32'h0, 32'd5, 32'd7, 32'h44, 32'd7, 1'b1};
    v[8]  = '{32'hAC220000, 2'b01, 2'b01, 5'd2, 5'd0, 32'h55, 32'h0, 32'd5, 32'd7, 32'd5, 32'h55, 1'b0};
    v[9]  = '{32'h10220000, 2'b10, 2'b10, 5'd0, 5'd1, 32'h0, 32'h66, 32'd5, 32'd7, 32'h66, 32'd7, 1'b0};
    v[10] = '{32'h00221080, 2'b01, 2'b01, 5'd1, 5'd0, 32'h77, 32'h0, 32'd5, 32'd7, 32'h77, 32'd7, 1'b1};
    v[11] = '{32'h20220005, 2'b01, 2'b01, 5'd2, 5'd0, 32'h88, 32'h0, 32'd5, 32'd7, 32'd5, 32'h88, 1'b1};
    v[12] = '{32'h00221821, 2'b11, 2'b01, 5'd1, 5'd1, 32'h1, 32'h2, 32'd5, 32'd7, 32'h1, 32'd7, 1'b0};

    rst = 1'b0;
    in_valid = 1'b1;
    in_pc = 32'h1234;
    in_inst = 32'h00221821;
    flush = 1'b0;
    out_ready = 1'b1;
    clr_cnt = 1'b0;
    rf_rdata1 = 32'd0;
    rf_rdata2 = 32'd0;
    byp(2'b11, 2'b11, 5'd1, 5'd2, 32'd1, 32'd2);
    #3;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset stall_cycles", stall_cycles, 0);
    chk("reset out_pc", out_pc, 0);
    #10;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    byp(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    step();

    for (int k = 0; k < 13; k++) begin
      load(32'h1000 + 32'(k * 4), v[k].inst);
      byp(v[k].bv, v[k].bp, v[k].wa0, v[k].wa1, v[k].wd0, v[k].wd1);
      rf_rdata1 = v[k].rf1;
      rf_rdata2 = v[k].rf2;
      #1;
      chk($sformatf("vec%0d rs_val", k), out_rs_val, v[k].ers);
      chk($sformatf("vec%0d rt_val", k), out_rt_val, v[k].ert);
      chk($sformatf("vec%0d out_valid", k), out_valid, v[k].ev);
      chk($sformatf("vec%0d raddr1", k), rf_raddr1, v[k].inst[25:21]);
      chk($sformatf("vec%0d raddr2", k), rf_raddr2, v[k].inst[20:16]);
      chk($sformatf("vec%0d out_inst", k), out_inst, v[k].inst);
      drain();
      chk($sformatf("vec%0d drained", k), out_valid, 0);
    end

    // Load-use: two stall cycles, then the operand resolves combinationally.
    load(32'h2000, 32'h00221821);
    byp(2'b01, 2'b01, 5'd1, 5'd0, 32'hBEEF, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("loaduse c0 out_valid", out_valid, 0);
    chk("loaduse c0 in_ready", in_ready, 0);
    step();
    chk("loaduse c1 out_valid", out_valid, 0);
    chk("loaduse c1 in_ready", in_ready, 0);
    step();
    byp_pending = 2'b00;
    #1;
    chk("loaduse stall_cycles", stall_cycles, 2);
    chk("loaduse resolved out_valid", out_valid, 1);
    chk("loaduse resolved rs_val", out_rs_val, 32'hBEEF);
    step();
    chk("loaduse transferred", out_valid, 0);
    drain();

    // Saturation and clear-over-increment.
    load(32'h2100, 32'h00221821);
    byp(2'b01, 2'b01, 5'd1, 5'd0, 32'd0, 32'd0);
    repeat (20) step();
    chk("saturate stall_cycles", stall_cycles, 15);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clear wins stall_cycles", stall_cycles, 0);
    step();
    chk("count resumes stall_cycles", stall_cycles, 1);
    drain();

    // Back-to-back capture with transfer, then flush of held and offered.
    load(32'h100, 32'h00221821);
    in_valid = 1'b1;
    in_pc = 32'h200;
    in_inst = 32'hAC220000;
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b out_pc", out_pc, 32'h200);
    chk("b2b out_valid", out_valid, 1);
    in_valid = 1'b1;
    in_pc = 32'h300;
    in_inst = 32'h20220005;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    chk("flush out_pc", out_pc, 32'h200);
    step();
    chk("flush stays empty", out_valid, 0);

    // Asynchronous reset while an instruction is held.
    load(32'h400, 32'h00221821);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out_pc", out_pc, 0);
    step();
    rst = 1'b1;
    step();
    chk("post reset out_valid", out_valid, 0);

    m_held = 1'b0;
    m_pc = 32'd0;
    m_inst = 32'd0;
    m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom);
      flush = $urandom_range(7) == 0;
      out_ready = 1'($urandom);
      clr_cnt = $urandom_range(15) == 0;
      in_pc = $urandom;
      in_inst = {ops[$urandom_range(8)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                 10'($urandom), fns[$urandom_range(3)]};
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      byp(2'($urandom), 2'($urandom), 5'($urandom_range(3)), 5'($urandom_range(3)), $urandom, $urandom);
      #1;
      m_res(m_inst[25:21], rf_rdata1, rsv, prs);
      m_res(m_inst[20:16], rf_rdata2, rtv, prt);
      haz = m_held && ((m_uses_rs(m_inst) && prs) || (m_uses_rt(m_inst) && prt));
      ev = m_held && !haz;
      er = !m_held || (ev && out_ready);
      chk("rand out_valid", out_valid, ev);
      chk("rand in_ready", in_ready, er);
      chk("rand rs_val", out_rs_val, rsv);
      chk("rand rt_val", out_rt_val, rtv);
      chk("rand out_pc", out_pc, m_pc);
      chk("rand stall_cycles", stall_cycles, m_cnt);
      @(posedge clk);
      if (clr_cnt) m_cnt = 0;
      else if (haz && m_cnt < 15) m_cnt++;
      if (flush) m_held = 1'b0;
      else if (in_valid && er) begin
        m_held = 1'b1;
        m_pc = in_pc;
        m_inst = in_inst;
      end else if (ev && out_ready) m_held = 1'b0;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
